step_ramp_controller: RTL
=========================

// Module: step_ramp_controller
// PURPOSE
//  Trapezoidal step-rate sequencer for one stepper axis. Accepts a move command (step count,
//  direction, ramp profile) over a valid/ready handshake and emits step/dir pulses. The step
//  period ramps from a start period down to a cruise period and back up.
//  Contains its own programmable period counter (divide-by-N, same semantics as clk_divider)
//  and sits between the motion command source and the motor driver pins.
// PARAMETERS
//  CNT_SIZE   16  width of all period/acceleration values (clock cycles)
//  STEP_SIZE  32  width of step count and internal step counters
//  PULSE_LEN  4   step_out high time in clk_in cycles; minimum legal period = 2*PULSE_LEN
// PORTS
//  clk_in           input   1          system clock; all logic on posedge
//  reset_n_in       input   1          asynchronous, active-low reset
//  cmd_valid_in     input   1          command valid
//  cmd_ready_out    output  1          command ready (1 only in IDLE)
//  cmd_steps_in     input   STEP_SIZE  number of steps to issue
//  cmd_dir_in       input   1          direction for the move
//  start_period_in  input   CNT_SIZE   first/last step period (cycles)
//  min_period_in    input   CNT_SIZE   cruise step period (cycles)
//  accel_in         input   CNT_SIZE   period change per step during ramps
//  step_out         output  1          step pulse to driver
//  dir_out          output  1          direction to driver, stable for whole move
//  busy_out         output  1          1 from accept until DONE completes
//  done_out         output  1          one-cycle pulse when the last step period ends
//  period_out       output  CNT_SIZE   period of the step currently being issued
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE.
//    step_out=0, dir_out=0, busy_out=0, done_out=0, period_out=0, cmd_ready_out=1.
//  - Handshake: command accepted on the posedge where cmd_valid_in && cmd_ready_out.
//    All cmd_* fields are latched at that edge; later input changes are ignored until IDLE.
//  - States: IDLE, ACCEL, CRUISE, DECEL, DONE.
//    On accept: steps==0 -> DONE. min>=start -> CRUISE at start. Otherwise -> ACCEL at start.
//    Period clamping:
//      - start clamped up to 2*PULSE_LEN; min clamped into [2*PULSE_LEN, start].
//  - Timing: step_out rises the cycle after accept, stays high PULSE_LEN cycles, then low
//    until the current period expires. The next step rises immediately at expiry (no gap).
//  - End of each step period:
//      1. remaining -= 1.
//      2. If remaining==0 -> DONE.
//      3. Else if state in {ACCEL, CRUISE} and remaining <= ramp_steps -> DECEL,
//         period = min(period+accel, start).
//      4. Else if ACCEL -> period = max(period-accel, min), ramp_steps += 1;
//         if period reaches min -> CRUISE.
//      5. Else if DECEL -> period = min(period+accel, start).
//  - Arithmetic: CNT_SIZE+1-bit add/subtract, saturating at clamps; no wrap-around.
//    accel_in==0 -> never leaves ACCEL by ramp; the move is constant-period at start.
//  - DONE: done_out=1 for exactly one cycle, then IDLE. cmd_ready_out=1 the cycle after DONE.
//  - busy_out = (state != IDLE). dir_out holds its latched value after the move.
// CONFIGURATION
//  STEP_RAMP_ABORT_EN defined: adds port abort_in (input, 1).
//    abort_in=1 in ACCEL/CRUISE -> DECEL next edge, remaining=ramp_steps+1, period unchanged;
//    ramp_steps==0 -> finish current step, then DONE.
//    Current step pulse is never truncated. Ignored in IDLE/DECEL/DONE.
//  Undefined: no abort_in port; a move always runs to completion.
// TESTING
//  1. steps=0, start=100 -> no step_out pulse; done_out high 1 cycle at accept+1; ready after.
//  2. steps=10, start=min=100, accel=20 -> 10 pulses 100 cycles apart, each 4 cycles wide;
//     done at accept+1001.
//  3. steps=10, start=100, min=40, accel=20 -> periods 100,80,60,40,40,40,40,60,80,100;
//     done at accept+641.
//  4. steps=4, start=100, min=40, accel=20 -> periods 100,80,60,80; dir_out stable throughout.
//  5. reset_n_in low mid-CRUISE -> step_out/busy_out drop immediately, no done_out; new cmd OK.
//  6. (ABORT_EN) test 3 with abort_in at start of step 5 -> periods 100,80,60,40,40,60,80,100.

Source files
------------

// File: rtl/step_ramp_controller_if.sv
// Command channel of step_ramp_controller: valid/ready handshake carrying one move
// (step count, direction, start/cruise period, per-step acceleration).
interface step_ramp_controller_if #(
  parameter int CNT_SIZE  = 16,
  parameter int STEP_SIZE = 32
);
  logic                 cmd_valid_in;
  logic                 cmd_ready_out;
  logic [STEP_SIZE-1:0] cmd_steps_in;
  logic                 cmd_dir_in;
  logic [CNT_SIZE-1:0]  start_period_in;
  logic [CNT_SIZE-1:0]  min_period_in;
  logic [CNT_SIZE-1:0]  accel_in;

  modport master (
    output cmd_valid_in, cmd_steps_in, cmd_dir_in,
    output start_period_in, min_period_in, accel_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in, cmd_steps_in, cmd_dir_in,
    input  start_period_in, min_period_in, accel_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/step_ramp_controller.sv
// Trapezoidal step-rate sequencer for one stepper axis (IDLE/ACCEL/CRUISE/DECEL/DONE).
// Optional STEP_RAMP_ABORT_EN adds abort_in, which forces an early symmetric deceleration.
module step_ramp_controller #(
  parameter int CNT_SIZE  = 16,
  parameter int STEP_SIZE = 32,
  parameter int PULSE_LEN = 4
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  step_ramp_controller_if.slave cmd_if,
`ifdef STEP_RAMP_ABORT_EN
  input  logic                abort_in,
`endif
  output logic                step_out,
  output logic                dir_out,
  output logic                busy_out,
  output logic                done_out,
  output logic [CNT_SIZE-1:0] period_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEL  = 3'd1;
  localparam logic [2:0] S_CRUISE = 3'd2;
  localparam logic [2:0] S_DECEL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_SIZE-1:0] MIN_P   = CNT_SIZE'(2 * PULSE_LEN);
  localparam logic [CNT_SIZE-1:0] PULSE_W = CNT_SIZE'(PULSE_LEN);

  logic [2:0]           state_q, state_d;
  logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
  logic [CNT_SIZE-1:0]  period_q, period_d;
  logic [CNT_SIZE-1:0]  start_q, start_d;
  logic [CNT_SIZE-1:0]  min_q, min_d;
  logic [CNT_SIZE-1:0]  accel_q, accel_d;
  logic [STEP_SIZE-1:0] remaining_q, remaining_d;
  logic [STEP_SIZE-1:0] ramp_q, ramp_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 done_q, done_d;

  logic [CNT_SIZE-1:0]  start_c, min_c;
  logic [CNT_SIZE:0]    inc_sum, dec_sum;
  logic [CNT_SIZE-1:0]  period_up, period_dn;
  logic                 period_end;
  logic [2:0]           st_eff;
  logic [STEP_SIZE-1:0] rem_eff, rem_next;

  // Incoming periods are clamped so a period always fits a full pulse plus equal low time.
  always_comb begin
    start_c = (cmd_if.start_period_in < MIN_P) ? MIN_P : cmd_if.start_period_in;
    if (cmd_if.min_period_in < MIN_P)
      min_c = MIN_P;
    else if (cmd_if.min_period_in > start_c)
      min_c = start_c;
    else
      min_c = cmd_if.min_period_in;
  end

  // One extra bit keeps the ramp arithmetic from wrapping; results saturate at min/start.
  always_comb begin
    inc_sum    = {1'b0, period_q} + {1'b0, accel_q};
    dec_sum    = {1'b0, period_q} - {1'b0, accel_q};
    period_up  = (inc_sum >= {1'b0, start_q}) ? start_q : inc_sum[CNT_SIZE-1:0];
    period_dn  = (dec_sum[CNT_SIZE] || (dec_sum[CNT_SIZE-1:0] <= min_q)) ? min_q
                                                                         : dec_sum[CNT_SIZE-1:0];
    period_end = (({1'b0, cnt_q} + (CNT_SIZE+1)'(1)) == {1'b0, period_q});
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    start_d     = start_q;
    min_d       = min_q;
    accel_d     = accel_q;
    remaining_d = remaining_q;
    ramp_d      = ramp_q;
    dir_d       = dir_q;
    st_eff      = state_q;
    rem_eff     = remaining_q;
    rem_next    = remaining_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid_in) begin
          start_d     = start_c;
          min_d       = min_c;
          accel_d     = cmd_if.accel_in;
          dir_d       = cmd_if.cmd_dir_in;
          remaining_d = cmd_if.cmd_steps_in;
          ramp_d      = '0;
          cnt_d       = '0;
          period_d    = start_c;
          if (cmd_if.cmd_steps_in == '0)
            state_d = S_DONE;
          else if (min_c == start_c)
            state_d = S_CRUISE;
          else
            state_d = S_ACCEL;
        end
      end

      S_ACCEL, S_CRUISE, S_DECEL: begin
`ifdef STEP_RAMP_ABORT_EN
        // Abort mirrors the ramp already climbed; the step in flight still completes.
        if (abort_in && (state_q != S_DECEL)) begin
          st_eff  = S_DECEL;
          rem_eff = ramp_q + STEP_SIZE'(1);
        end
`endif
        state_d     = st_eff;
        remaining_d = rem_eff;
        if (period_end) begin
          cnt_d       = '0;
          rem_next    = rem_eff - STEP_SIZE'(1);
          remaining_d = rem_next;
          if (rem_next == '0) begin
            state_d = S_DONE;
          end else if ((st_eff != S_DECEL) && (rem_next <= ramp_q)) begin
            state_d  = S_DECEL;
            period_d = period_up;
          end else if (st_eff == S_ACCEL) begin
            period_d = period_dn;
            ramp_d   = ramp_q + STEP_SIZE'(1);
            if (period_dn == min_q)
              state_d = S_CRUISE;
          end else if (st_eff == S_DECEL) begin
            period_d = period_up;
          end
        end else begin
          cnt_d = cnt_q + CNT_SIZE'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    step_d = ((state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL)) &&
             (cnt_d < PULSE_W);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      start_q     <= '0;
      min_q       <= '0;
      accel_q     <= '0;
      remaining_q <= '0;
      ramp_q      <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      start_q     <= start_d;
      min_q       <= min_d;
      accel_q     <= accel_d;
      remaining_q <= remaining_d;
      ramp_q      <= ramp_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  assign cmd_if.cmd_ready_out = (state_q == S_IDLE);
  assign busy_out             = (state_q != S_IDLE);
  assign step_out             = step_q;
  assign done_out             = done_q;
  assign dir_out              = dir_q;
  assign period_out           = period_q;

endmodule
